// File: rtl/input_port_if.sv
// Signal bundle between the input port and its producer/controller.
// The master drives the producer and controller inputs; the slave is the port itself.
interface input_port_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] ext_data;
  logic             ext_valid;
  logic             ext_ready;
  logic             ei;
  logic [WIDTH-1:0] busout;
  logic             avail;
  logic [CW-1:0]    count;
  logic             underflow;

  modport master (
    output ext_data, ext_valid, ei,
    input  ext_ready, busout, avail, count, underflow
  );

  modport slave (
    input  ext_data, ext_valid, ei,
    output ext_ready, busout, avail, count, underflow
  );
endinterface

// File: rtl/input_port.sv
// Input port: a valid/ready byte FIFO that is drained onto the CPU bus while ei is high.
// busout is zero whenever no pop happens, so the port can be OR-muxed onto the bus.
module input_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input_port_if.slave  port
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             uflow;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // DEPTH is a power of two, so the natural AW-bit rollover is the modulo wrap.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  always_comb begin
    full  = (cnt == FULL_CNT);
    empty = (cnt == '0);
    push  = port.ext_valid && !full;
    pop   = port.ei && !empty;
  end

  assign port.ext_ready = !full;
  assign port.avail     = !empty;
  assign port.count     = cnt;
  assign port.underflow = uflow;
  // No write-through: a byte pushed into an empty FIFO is not visible until the next cycle.
  assign port.busout    = pop ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      uflow <= 1'b0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (port.ei && empty) uflow <= 1'b1;
    end
  end

  // Storage carries no reset; contents are don't-care after clr.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr] <= port.ext_data;
  end
endmodule

// File: tb/tb_input_port.sv
// Bench for input_port: directed scenarios plus random traffic checked against a queue model.
module tb_input_port;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  input_port_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) pif ();
  input_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .clr  (clr),
    .port (pif.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q[$];
  bit               mu;
  bit               known = 1'b0;

  logic [WIDTH-1:0] last_bus;
  logic             last_rdy;
  logic             last_av;
  logic [CW-1:0]    last_cnt;
  logic             last_uf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, sample mid-cycle, compare with the model, then advance the model.
  task automatic step(input logic c, input logic v, input logic [WIDTH-1:0] d, input logic e);
    bit pu;
    bit po;
    logic [31:0] exp_bus;
    clr = c;
    pif.ext_valid = v;
    pif.ext_data  = d;
    pif.ei        = e;
    @(negedge clk);
    last_bus = pif.busout;
    last_rdy = pif.ext_ready;
    last_av  = pif.avail;
    last_cnt = pif.count;
    last_uf  = pif.underflow;
    if (known) begin
      exp_bus = (e && q.size() != 0) ? 32'(q[0]) : 32'd0;
      chk("ready", 32'(pif.ext_ready), 32'(q.size() != DEPTH));
      chk("avail", 32'(pif.avail), 32'(q.size() != 0));
      chk("count", 32'(pif.count), 32'(q.size()));
      chk("underflow", 32'(pif.underflow), 32'(mu));
      chk("busout", 32'(pif.busout), exp_bus);
    end
    if (c) begin
      q.delete();
      mu = 1'b0;
      known = 1'b1;
    end else begin
      pu = v && (q.size() < DEPTH);
      po = e && (q.size() != 0);
      if (e && q.size() == 0) mu = 1'b1;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1;
    pif.ext_valid = 1'b0;
    pif.ext_data  = '0;
    pif.ei        = 1'b0;
    step(1, 0, 8'h00, 0);

    // reset mid-traffic
    step(0, 1, 8'hC1, 0);
    step(0, 1, 8'hC2, 0);
    step(1, 1, 8'h77, 1);
    step(0, 0, 8'h00, 1);
    chk("rst_cnt", 32'(last_cnt), 32'd0);
    chk("rst_av", 32'(last_av), 32'd0);
    chk("rst_rdy", 32'(last_rdy), 32'd1);
    chk("rst_uf", 32'(last_uf), 32'd0);
    chk("rst_bus", 32'(last_bus), 32'd0);
    step(1, 0, 8'h00, 0);

    // ordering
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h22, 0);
    step(0, 1, 8'h33, 0);
    step(0, 0, 8'h00, 1);
    chk("ord_b0", 32'(last_bus), 32'h11);
    chk("ord_c0", 32'(last_cnt), 32'd3);
    step(0, 0, 8'h00, 1);
    chk("ord_b1", 32'(last_bus), 32'h22);
    chk("ord_c1", 32'(last_cnt), 32'd2);
    step(0, 0, 8'h00, 1);
    chk("ord_b2", 32'(last_bus), 32'h33);
    chk("ord_c2", 32'(last_cnt), 32'd1);
    step(0, 0, 8'h00, 0);
    chk("ord_av", 32'(last_av), 32'd0);
    chk("ord_c3", 32'(last_cnt), 32'd0);

    // full
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'hA0 + i), 0);
    step(0, 1, 8'hA4, 0);
    chk("full_rdy", 32'(last_rdy), 32'd0);
    chk("full_cnt", 32'(last_cnt), 32'd4);
    step(0, 1, 8'hA4, 1);
    chk("full_rd", 32'(last_bus), 32'hA0);
    step(0, 1, 8'hA4, 0);
    chk("full_rdy2", 32'(last_rdy), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 0, 8'h00, 1);
      chk("full_drain", 32'(last_bus), 32'(8'hA0 + i));
    end

    // simultaneous push and pop
    step(0, 1, 8'h55, 0);
    step(0, 1, 8'h5A, 0);
    step(0, 1, 8'h66, 1);
    chk("sim_bus", 32'(last_bus), 32'h55);
    step(0, 0, 8'h00, 0);
    chk("sim_cnt", 32'(last_cnt), 32'd2);
    step(0, 0, 8'h00, 1);
    chk("sim_r1", 32'(last_bus), 32'h5A);
    step(0, 0, 8'h00, 1);
    chk("sim_r2", 32'(last_bus), 32'h66);

    // pointer wrap
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 8'(i), 0);
      step(0, 0, 8'h00, 1);
      chk("wrap", 32'(last_bus), 32'(i));
    end

    // underflow
    step(0, 0, 8'h00, 1);
    chk("uf_bus", 32'(last_bus), 32'd0);
    chk("uf_cnt", 32'(last_cnt), 32'd0);
    step(0, 1, 8'h9C, 0);
    chk("uf_set", 32'(last_uf), 32'd1);
    step(0, 0, 8'h00, 1);
    chk("uf_rd", 32'(last_bus), 32'h9C);
    step(0, 0, 8'h00, 0);
    chk("uf_sticky", 32'(last_uf), 32'd1);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    chk("uf_clr", 32'(last_uf), 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 2) != 0,
           WIDTH'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
